// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one registered Wishbone master port among NUM_REQ requesters.
// Define WB_ARB_TIMEOUT_EN to add the ack watchdog that errors out a stalled BUSY cycle.
module wb_master_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 2,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            s_cyc_i,
   input  logic [NUM_REQ-1:0]            s_stb_i,
   input  logic [NUM_REQ-1:0]            s_we_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_adr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] s_dat_i,
   output logic [NUM_REQ-1:0]            s_ack_o,
   output logic [NUM_REQ-1:0]            s_err_o,
   output logic [DATA_WIDTH-1:0]         s_dat_o,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic                          m_cyc_o,
   output logic                          m_stb_o,
   output logic                          m_we_o,
   output logic [ADDR_WIDTH-1:0]         m_adr_o,
   output logic [DATA_WIDTH-1:0]         m_dat_o,
   input  logic                          m_ack_i,
   input  logic [DATA_WIDTH-1:0]         m_dat_i
);

   generate
      if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
         $error("wb_master_arbiter: NUM_REQ must be in 2..4");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("wb_master_arbiter: TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);

   state_t                  state_q, state_d;
   logic [1:0]              ptr_q, ptr_d;
   logic [1:0]              g_q, g_d;
   logic [NUM_REQ-1:0]      gnt_q, gnt_d;
   logic [NUM_REQ-1:0]      s_ack_q, s_ack_d;
   logic [DATA_WIDTH-1:0]   s_dat_q, s_dat_d;
   logic                    m_cyc_q, m_cyc_d;
   logic                    m_stb_q, m_stb_d;
   logic                    m_we_q, m_we_d;
   logic [ADDR_WIDTH-1:0]   m_adr_q, m_adr_d;
   logic [DATA_WIDTH-1:0]   m_dat_q, m_dat_d;

   logic [NUM_REQ-1:0]      req;
   logic                    found;
   logic [1:0]              win;
   logic [2:0]              sum;
   logic [NUM_REQ-1:0]      win_oh;
   logic [NUM_REQ-1:0]      g_oh;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_adr;
   logic [DATA_WIDTH-1:0]   sel_dat;
   logic                    cyc_g;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]           timer_q, timer_d;
   logic [NUM_REQ-1:0]      s_err_q, s_err_d;
`endif

   assign req = s_cyc_i & s_stb_i;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == LAST_IDX) ? 2'd0 : i + 2'd1;
   endfunction

   // First requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr_q} + 3'(i);
         if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k] && sum[1:0] == 2'(k)) begin
               found = 1'b1;
               win   = 2'(k);
            end
         end
      end
   end

   always_comb begin
      win_oh  = '0;
      g_oh    = '0;
      sel_we  = 1'b0;
      sel_adr = '0;
      sel_dat = '0;
      cyc_g   = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (win == 2'(k)) begin
            win_oh[k] = 1'b1;
            sel_we    = s_we_i[k];
            sel_adr   = s_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            sel_dat   = s_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
         if (g_q == 2'(k)) begin
            g_oh[k] = 1'b1;
            cyc_g   = s_cyc_i[k];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      g_d     = g_q;
      gnt_d   = gnt_q;
      s_ack_d = '0;
      s_dat_d = s_dat_q;
      m_cyc_d = m_cyc_q;
      m_stb_d = m_stb_q;
      m_we_d  = m_we_q;
      m_adr_d = m_adr_q;
      m_dat_d = m_dat_q;
`ifdef WB_ARB_TIMEOUT_EN
      timer_d = timer_q;
      s_err_d = '0;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               g_d     = win;
               gnt_d   = win_oh;
               m_we_d  = sel_we;
               m_adr_d = sel_adr;
               m_dat_d = sel_dat;
               m_cyc_d = 1'b1;
               m_stb_d = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
               timer_d = '0;
`endif
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Ack has priority over both abort and watchdog expiry.
            if (m_ack_i) begin
               m_cyc_d = 1'b0;
               m_stb_d = 1'b0;
               m_we_d  = 1'b0;
               s_ack_d = g_oh;
               if (!m_we_q) s_dat_d = m_dat_i;
               ptr_d   = next_idx(g_q);
               state_d = RELEASE;
            end else if (!cyc_g) begin
               m_cyc_d = 1'b0;
               m_stb_d = 1'b0;
               m_we_d  = 1'b0;
               ptr_d   = next_idx(g_q);
               state_d = RELEASE;
            end
`ifdef WB_ARB_TIMEOUT_EN
            else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               m_cyc_d = 1'b0;
               m_stb_d = 1'b0;
               m_we_d  = 1'b0;
               s_err_d = g_oh;
               ptr_d   = next_idx(g_q);
               state_d = RELEASE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
`endif
         end
         RELEASE: begin
            gnt_d   = '0;
            m_adr_d = '0;
            m_dat_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         g_q     <= '0;
         gnt_q   <= '0;
         s_ack_q <= '0;
         s_dat_q <= '0;
         m_cyc_q <= 1'b0;
         m_stb_q <= 1'b0;
         m_we_q  <= 1'b0;
         m_adr_q <= '0;
         m_dat_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         gnt_q   <= gnt_d;
         s_ack_q <= s_ack_d;
         s_dat_q <= s_dat_d;
         m_cyc_q <= m_cyc_d;
         m_stb_q <= m_stb_d;
         m_we_q  <= m_we_d;
         m_adr_q <= m_adr_d;
         m_dat_q <= m_dat_d;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         timer_q <= '0;
         s_err_q <= '0;
      end else begin
         timer_q <= timer_d;
         s_err_q <= s_err_d;
      end
   end
   assign s_err_o = s_err_q;
`else
   assign s_err_o = '0;
`endif

   assign s_ack_o = s_ack_q;
   assign s_dat_o = s_dat_q;
   assign gnt_o   = gnt_q;
   assign m_cyc_o = m_cyc_q;
   assign m_stb_o = m_stb_q;
   assign m_we_o  = m_we_q;
   assign m_adr_o = m_adr_q;
   assign m_dat_o = m_dat_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed plus randomized bench for wb_master_arbiter with three requesters and a
// transaction-level round-robin model; covers the watchdog when WB_ARB_TIMEOUT_EN is set.
module tb_wb_master_arbiter;
   localparam int N  = 3;
   localparam int AW = 2;
   localparam int DW = 8;
   localparam int TO = 64;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [N-1:0]    s_cyc_i, s_stb_i, s_we_i;
   logic [N*AW-1:0] s_adr_i;
   logic [N*DW-1:0] s_dat_i;
   logic [N-1:0]    s_ack_o, s_err_o, gnt_o;
   logic [DW-1:0]   s_dat_o, m_dat_o, m_dat_i;
   logic            m_cyc_o, m_stb_o, m_we_o, m_ack_i;
   logic [AW-1:0]   m_adr_o;

   int tests  = 0;
   int failed = 0;

   // Reference model: round-robin pointer, captured read data, per-requester current request.
   int            ptr_m;
   logic [DW-1:0] sdat_m;
   logic          act[N];
   logic          cur_we[N];
   logic [AW-1:0] cur_adr[N];
   logic [DW-1:0] cur_dat[N];
   int            pend[N];

   always #5 clk_i = ~clk_i;

   wb_master_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
      .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
      .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_dat_o(s_dat_o), .gnt_o(gnt_o),
      .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
      .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
   );

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, failed=%0d", failed);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] oh(input int k);
      return 32'd1 << k;
   endfunction

   task automatic drive(input int k, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
      s_cyc_i[k] = 1'b1;
      s_stb_i[k] = 1'b1;
      s_we_i[k]  = we;
      s_adr_i[k*AW +: AW] = adr;
      s_dat_i[k*DW +: DW] = dat;
      act[k] = 1'b1;
      cur_we[k] = we;
      cur_adr[k] = adr;
      cur_dat[k] = dat;
   endtask

   task automatic load_rand(input int k);
      drive(k, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
   endtask

   task automatic drop(input int k);
      s_cyc_i[k] = 1'b0;
      s_stb_i[k] = 1'b0;
      act[k] = 1'b0;
   endtask

   function automatic int pick();
      for (int i = 0; i < N; i++) begin
         int k;
         k = (ptr_m + i) % N;
         if (act[k]) return k;
      end
      return -1;
   endfunction

   // Called one cycle after the arbitration edge: bus must carry the model's winner.
   task automatic expect_grant(output int g);
      int w;
      w = pick();
      check("grant", gnt_o, (w < 0) ? 32'd0 : oh(w));
      g = (w < 0) ? 0 : w;
      check("grant_cyc", m_cyc_o, 1);
      check("grant_stb", m_stb_o, 1);
      check("grant_we", m_we_o, cur_we[g]);
      check("grant_adr", m_adr_o, cur_adr[g]);
      check("grant_dat", m_dat_o, cur_dat[g]);
   endtask

   task automatic complete(input int g, input int delay, input logic [DW-1:0] rdat, input bit abort_same);
      for (int d = 0; d < delay; d++) begin
         tick();
         check("busy_cyc", m_cyc_o, 1);
         check("busy_we", m_we_o, cur_we[g]);
         check("busy_adr", m_adr_o, cur_adr[g]);
         check("busy_dat", m_dat_o, cur_dat[g]);
         check("busy_no_ack", s_ack_o, 0);
      end
      m_ack_i = 1'b1;
      m_dat_i = rdat;
      if (abort_same) drop(g);
      tick();
      m_ack_i = 1'b0;
      m_dat_i = DW'($urandom);
      if (!cur_we[g]) sdat_m = rdat;
      ptr_m = (g + 1) % N;
      check("ack_pulse", s_ack_o, oh(g));
      check("ack_cyc_low", m_cyc_o, 0);
      check("ack_stb_low", m_stb_o, 0);
      check("ack_no_err", s_err_o, 0);
      check("ack_sdat", s_dat_o, sdat_m);
   endtask

   task automatic finish_release();
      tick();
      check("rel_ack_low", s_ack_o, 0);
      check("rel_err_low", s_err_o, 0);
      check("rel_gnt_low", gnt_o, 0);
      check("rel_cyc_low", m_cyc_o, 0);
   endtask

   task automatic run_rr(input bit allow_join, input int max_iter);
      int g;
      for (int it = 0; it < max_iter; it++) begin
         int any;
         any = 0;
         for (int k = 0; k < N; k++) if (pend[k] > 0) any = 1;
         if (any == 0) break;
         tick();
         expect_grant(g);
         complete(g, $urandom_range(0, 3), DW'($urandom), 1'b0);
         pend[g]--;
         if (pend[g] > 0) load_rand(g);
         else drop(g);
         if (allow_join) begin
            for (int k = 0; k < N; k++) begin
               if (k != g && pend[k] == 0 && $urandom_range(0, 3) == 0) begin
                  pend[k] = $urandom_range(1, 2);
                  load_rand(k);
               end
            end
         end
         finish_release();
      end
      for (int k = 0; k < N; k++) begin
         drop(k);
         pend[k] = 0;
      end
   endtask

   initial begin
      int g;
      int n;
      int bad;
      rst_i   = 1'b0;
      s_cyc_i = '0;
      s_stb_i = '0;
      s_we_i  = '0;
      s_adr_i = '0;
      s_dat_i = '0;
      m_ack_i = 1'b0;
      m_dat_i = '0;
      ptr_m   = 0;
      sdat_m  = '0;
      for (int k = 0; k < N; k++) begin
         act[k] = 1'b0;
         pend[k] = 0;
         cur_we[k] = 1'b0;
         cur_adr[k] = '0;
         cur_dat[k] = '0;
      end

      // Reset state
      #20;
      check("rst_gnt", gnt_o, 0);
      check("rst_cyc", m_cyc_o, 0);
      check("rst_stb", m_stb_o, 0);
      check("rst_we", m_we_o, 0);
      check("rst_adr", m_adr_o, 0);
      check("rst_mdat", m_dat_o, 0);
      check("rst_ack", s_ack_o, 0);
      check("rst_err", s_err_o, 0);
      check("rst_sdat", s_dat_o, 0);
      #113 rst_i = 1'b1;
      tick();

      // Single write from requester 0, slave acks 3 cycles after m_cyc_o
      drive(0, 1'b1, 2'd2, 8'hC5);
      tick();
      expect_grant(g);
      complete(g, 2, 8'h3C, 1'b0);
      drop(0);
      finish_release();

      // Read from requester 1
      drive(1, 1'b0, 2'd1, 8'h00);
      tick();
      expect_grant(g);
      complete(g, 1, 8'h80, 1'b0);
      drop(1);
      finish_release();

      // Contention: all requesters, four transactions each
      for (int k = 0; k < N; k++) begin
         pend[k] = 4;
         load_rand(k);
      end
      run_rr(1'b0, 20);
      check("contention_ptr_consumed", pend[0] + pend[1] + pend[2], 0);

      // Abort by requester 0 before ack; next grant goes to requester 1
      drive(0, 1'b1, 2'd3, 8'h5A);
      tick();
      expect_grant(g);
      tick();
      check("pre_abort_cyc", m_cyc_o, 1);
      drop(0);
      tick();
      ptr_m = (g + 1) % N;
      check("abort_cyc", m_cyc_o, 0);
      check("abort_stb", m_stb_o, 0);
      check("abort_no_ack", s_ack_o, 0);
      finish_release();
      drive(0, 1'b1, 2'd0, 8'h11);
      drive(1, 1'b1, 2'd1, 8'h22);
      tick();
      expect_grant(g);
      check("after_abort_is_1", g, 1);
      complete(g, 0, 8'h00, 1'b0);
      drop(1);
      finish_release();
      tick();
      expect_grant(g);
      complete(g, 1, 8'h00, 1'b0);
      drop(0);
      finish_release();

      // Reset while BUSY releases the bus asynchronously
      drive(2, 1'b0, 2'd2, 8'h00);
      tick();
      expect_grant(g);
      tick();
      #2 rst_i = 1'b0;
      #1;
      check("arst_cyc", m_cyc_o, 0);
      check("arst_stb", m_stb_o, 0);
      check("arst_gnt", gnt_o, 0);
      check("arst_ack", s_ack_o, 0);
      drop(2);
      tick();
      tick();
      check("arst_no_ack_later", s_ack_o, 0);
      ptr_m  = 0;
      sdat_m = '0;
      check("arst_sdat", s_dat_o, 0);
      rst_i = 1'b1;
      tick();

      // Ack and cyc drop in the same cycle: ack wins
      drive(1, 1'b0, 2'd3, 8'h00);
      tick();
      expect_grant(g);
      complete(g, 1, 8'hA7, 1'b1);
      finish_release();

      // Ack while idle is ignored
      m_ack_i = 1'b1;
      m_dat_i = 8'hEE;
      tick();
      tick();
      check("idle_ack_ignored", s_ack_o, 0);
      check("idle_ack_cyc", m_cyc_o, 0);
      check("idle_ack_sdat", s_dat_o, sdat_m);
      m_ack_i = 1'b0;

      // Randomized traffic with late joiners
      for (int k = 0; k < N; k++) begin
         pend[k] = $urandom_range(0, 3);
         if (pend[k] > 0) load_rand(k);
      end
      if (pend[0] == 0) begin
         pend[0] = 2;
         load_rand(0);
      end
      run_rr(1'b1, 60);

      // Stalled slave
      drive(0, 1'b1, 2'd1, 8'h99);
      tick();
      expect_grant(g);
`ifdef WB_ARB_TIMEOUT_EN
      n = 0;
      bad = 0;
      while (m_cyc_o === 1'b1 && n < 200) begin
         if (s_err_o !== '0 || s_ack_o !== '0) bad++;
         tick();
         n++;
      end
      check("timeout_busy_cycles", n, TO);
      check("timeout_err_pulse", s_err_o, oh(g));
      check("timeout_no_ack", s_ack_o, 0);
      check("timeout_no_early_err", bad, 0);
      ptr_m = (g + 1) % N;
      drop(0);
      finish_release();
`else
      n = 0;
      bad = 0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         n++;
         if (m_cyc_o !== 1'b1 || s_err_o !== '0 || s_ack_o !== '0) bad++;
      end
      check("no_timeout_hold", bad, 0);
      drop(0);
      tick();
      ptr_m = (g + 1) % N;
      check("stall_abort_cyc", m_cyc_o, 0);
      finish_release();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
